// File: rtl/mux_rr_feeder_4_if.sv
// Bundle between the round-robin feeder and its neighbours: requester
// handshakes on one side, the registered mux bus on the other.
interface mux_rr_feeder_4_if #(
    parameter int DATA_WIDTH = 96,
    parameter int NUM_PORTS  = 4,
    parameter int SEL_WIDTH  = 2
);
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_ready;
    logic                            stall;
    logic [NUM_PORTS*DATA_WIDTH-1:0] mux_in;
    logic [NUM_PORTS-1:0]            mux_in_valid;
    logic [SEL_WIDTH-1:0]            mux_sel;
    logic                            busy;

    modport master (
        output in_valid, in_data, stall,
        input  in_ready, mux_in, mux_in_valid, mux_sel, busy
    );

    modport slave (
        input  in_valid, in_data, stall,
        output in_ready, mux_in, mux_in_valid, mux_sel, busy
    );
endinterface

// File: rtl/mux_rr_feeder_4.sv
// Round-robin feeder for the 4:1 mux stage: per-port 2-entry FIFOs, one grant
// per cycle, data slot launched one cycle ahead of its matching sel/valid.
module mux_rr_feeder_4 #(
    parameter int DATA_WIDTH = 96,
    parameter int NUM_PORTS  = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_feeder_4_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [SEL_WIDTH-1:0] LAST_PORT = SEL_WIDTH'(NUM_PORTS - 1);

    logic [DATA_WIDTH-1:0]           mem_q    [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]            wr_ptr_q [NUM_PORTS];
    logic [PTR_WIDTH-1:0]            wr_ptr_d [NUM_PORTS];
    logic [PTR_WIDTH-1:0]            rd_ptr_q [NUM_PORTS];
    logic [PTR_WIDTH-1:0]            rd_ptr_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]            count_q  [NUM_PORTS];
    logic [CNT_WIDTH-1:0]            count_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0]            push_s;
    logic [NUM_PORTS-1:0]            pop_s;
    logic [NUM_PORTS-1:0]            nonempty_s;
    logic [NUM_PORTS-1:0]            nonempty_d_s;
    logic [SEL_WIDTH-1:0]            last_grant_q, last_grant_d;
    logic [SEL_WIDTH-1:0]            cand_s;
    logic                            gnt_vld_s, gnt_vld_q;
    logic [SEL_WIDTH-1:0]            gnt_idx_s, gnt_idx_q;
    logic [DATA_WIDTH-1:0]           head_s;
    logic [NUM_PORTS*DATA_WIDTH-1:0] mux_in_q, mux_in_d;
    logic [NUM_PORTS-1:0]            mux_in_valid_q, mux_in_valid_d;
    logic [SEL_WIDTH-1:0]            mux_sel_q, mux_sel_d;
    logic [NUM_PORTS-1:0]            in_ready_q, in_ready_d;
    logic                            busy_q, busy_d;

    function automatic logic [NUM_PORTS-1:0] onehot_f(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_PORTS-1:0] v;
        v      = {NUM_PORTS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Occupancy flags from registered counts; pushes this edge are not yet visible.
    always_comb begin
        nonempty_s = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            nonempty_s[i] = (count_q[i] != {CNT_WIDTH{1'b0}});
        end
    end

    // Round-robin search: lowest offset after last_grant wins, so scan offsets downward.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = last_grant_q;
        cand_s    = last_grant_q;
        if (!bus.stall) begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                cand_s    = last_grant_q + SEL_WIDTH'(k);
                gnt_idx_s = nonempty_s[cand_s] ? cand_s : gnt_idx_s;
                gnt_vld_s = gnt_vld_s | nonempty_s[cand_s];
            end
        end else begin
            gnt_vld_s = 1'b0;
            gnt_idx_s = last_grant_q;
        end
    end

    // FIFO pointers and counts: push on handshake, pop on grant.
    always_comb begin
        push_s       = {NUM_PORTS{1'b0}};
        pop_s        = {NUM_PORTS{1'b0}};
        nonempty_d_s = {NUM_PORTS{1'b0}};
        in_ready_d   = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            push_s[i]       = bus.in_valid[i] & in_ready_q[i];
            pop_s[i]        = gnt_vld_s & (gnt_idx_s == SEL_WIDTH'(i));
            count_d[i]      = count_q[i] + CNT_WIDTH'(push_s[i]) - CNT_WIDTH'(pop_s[i]);
            wr_ptr_d[i]     = push_s[i] ? (wr_ptr_q[i] + PTR_WIDTH'(1)) : wr_ptr_q[i];
            rd_ptr_d[i]     = pop_s[i]  ? (rd_ptr_q[i] + PTR_WIDTH'(1)) : rd_ptr_q[i];
            nonempty_d_s[i] = (count_d[i] != {CNT_WIDTH{1'b0}});
            in_ready_d[i]   = (count_d[i] < CNT_FULL);
        end
        busy_d = (|nonempty_d_s) | gnt_vld_s;
    end

    // Data slot loads at the grant edge; sel/valid follow one edge later from the grant register.
    always_comb begin
        head_s   = mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
        mux_in_d = mux_in_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            mux_in_d[i*DATA_WIDTH +: DATA_WIDTH] =
                pop_s[i] ? head_s : mux_in_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        mux_in_valid_d = gnt_vld_q ? onehot_f(gnt_idx_q) : {NUM_PORTS{1'b0}};
        mux_sel_d      = gnt_vld_q ? gnt_idx_q : mux_sel_q;
        last_grant_d   = gnt_vld_s ? gnt_idx_s : last_grant_q;
    end

    // Control, arbitration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                count_q[i]  <= {CNT_WIDTH{1'b0}};
                wr_ptr_q[i] <= {PTR_WIDTH{1'b0}};
                rd_ptr_q[i] <= {PTR_WIDTH{1'b0}};
            end
            last_grant_q   <= LAST_PORT;
            gnt_vld_q      <= 1'b0;
            gnt_idx_q      <= {SEL_WIDTH{1'b0}};
            mux_in_q       <= {(NUM_PORTS*DATA_WIDTH){1'b0}};
            mux_in_valid_q <= {NUM_PORTS{1'b0}};
            mux_sel_q      <= {SEL_WIDTH{1'b0}};
            in_ready_q     <= {NUM_PORTS{1'b1}};
            busy_q         <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                count_q[i]  <= count_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            last_grant_q   <= last_grant_d;
            gnt_vld_q      <= gnt_vld_s;
            gnt_idx_q      <= gnt_idx_s;
            mux_in_q       <= mux_in_d;
            mux_in_valid_q <= mux_in_valid_d;
            mux_sel_q      <= mux_sel_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    // Payload storage; left unreset because the counts decide what is visible.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_ptr_q[i]] <= bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.mux_in       = mux_in_q;
    assign bus.mux_in_valid = mux_in_valid_q;
    assign bus.mux_sel      = mux_sel_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mux_rr_feeder_4.sv
// Scoreboard bench for mux_rr_feeder_4: a queue-based reference model predicts
// every mux beat; a negedge monitor compares the DUT's beats against it.
module tb_mux_rr_feeder_4;
    localparam int DW = 96;
    localparam int NP = 4;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_feeder_4_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(2)) bus ();

    mux_rr_feeder_4 #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .SEL_WIDTH(2), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    bit            chk_en = 1'b0;
    bit            mon_en = 1'b0;
    bit            rst_v  = 1'b1;
    bit            stall_v = 1'b0;
    bit            model_busy = 1'b0;
    int            last_g = 3;
    logic [DW-1:0] mq [NP][$];
    logic [DW-1:0] src_list [NP][$];
    bit            src_valid [NP];
    logic [DW-1:0] src_data [NP];
    int            rate [NP];
    int            seq [NP];
    exp_t          exp_q [$];
    exp_t          mon_e;
    logic [NP*DW-1:0] mux_prev;

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_beat(input int p, input logic [DW-1:0] d);
        src_list[p].push_back(d);
    endtask

    // One clock: drive at negedge, check handshake outputs, advance the model at posedge.
    task automatic step();
        logic [NP-1:0]    vld;
        logic [NP-1:0]    rdy;
        logic [NP*DW-1:0] dat;
        bit               any_ne;
        int               g;
        @(negedge clk);
        vld = '0;
        rdy = '0;
        dat = '0;
        for (int i = 0; i < NP; i++) begin
            if (!src_valid[i]) begin
                if (src_list[i].size() > 0) begin
                    src_valid[i] = 1'b1;
                    src_data[i]  = src_list[i].pop_front();
                end else if (rate[i] > 0 && $urandom_range(99) < rate[i]) begin
                    src_valid[i] = 1'b1;
                    src_data[i]  = {32'(i + 1), 32'(seq[i]), 32'($urandom)};
                    seq[i]++;
                end
            end
            vld[i]           = src_valid[i];
            dat[i*DW +: DW]  = src_data[i];
            rdy[i]           = (mq[i].size() < 2);
        end
        rst          = rst_v;
        bus.in_valid = vld;
        bus.in_data  = dat;
        bus.stall    = stall_v;
        if (chk_en) begin
            chk("in_ready", bus.in_ready, rdy);
            chk("busy", bus.busy, model_busy);
        end
        @(posedge clk);
        cyc++;
        if (rst_v) begin
            for (int i = 0; i < NP; i++) begin
                mq[i].delete();
                src_list[i].delete();
                src_valid[i] = 1'b0;
            end
            exp_q.delete();
            last_g     = 3;
            model_busy = 1'b0;
        end else begin
            g = -1;
            if (!stall_v) begin
                for (int k = 1; k <= NP; k++) begin
                    if (g < 0 && mq[(last_g + k) % NP].size() > 0) g = (last_g + k) % NP;
                end
            end
            if (g >= 0) begin
                exp_q.push_back('{port: g, data: mq[g].pop_front(), due: cyc + 1});
                last_g = g;
            end
            for (int i = 0; i < NP; i++) begin
                if (vld[i] && rdy[i]) begin
                    mq[i].push_back(src_data[i]);
                    src_valid[i] = 1'b0;
                end
            end
            any_ne = 1'b0;
            for (int i = 0; i < NP; i++) any_ne = any_ne | (mq[i].size() > 0);
            model_busy = any_ne || (g >= 0);
        end
    endtask

    task automatic drain();
        int  n;
        bit  pending;
        for (int i = 0; i < NP; i++) rate[i] = 0;
        stall_v = 1'b0;
        n = 0;
        pending = 1'b1;
        while (pending && n < 60) begin
            step();
            n++;
            pending = (exp_q.size() > 0);
            for (int i = 0; i < NP; i++)
                pending = pending | src_valid[i] | (mq[i].size() > 0) | (src_list[i].size() > 0);
        end
        step();
        step();
        #1;
        chk("drained scoreboard", 32'(exp_q.size()), 0);
        chk("drained busy", bus.busy, 0);
    endtask

    // Monitor: the mux latches mux_in one edge before sel/valid, so compare the slot seen last cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mux_in_valid != '0) begin
                chk("valid onehot", 32'($countones(bus.mux_in_valid)), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected valid", bus.mux_in_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("mux_sel", bus.mux_sel, mon_e.port);
                    chk("mux_in_valid", bus.mux_in_valid, 1 << mon_e.port);
                    chk("slot data", mux_prev[mon_e.port*DW +: DW], mon_e.data);
                    chk("beat cycle", cyc, mon_e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                chk("missing beat", bus.mux_in_valid, 1 << mon_e.port);
            end
        end
        mux_prev = bus.mux_in;
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.stall    = 1'b0;
        for (int i = 0; i < NP; i++) begin
            rate[i]      = 0;
            seq[i]       = 0;
            src_valid[i] = 1'b0;
            src_data[i]  = '0;
        end

        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        #1;
        chk("reset mux_in", bus.mux_in, 0);
        chk("reset mux_in_valid", bus.mux_in_valid, 0);
        chk("reset mux_sel", bus.mux_sel, 0);
        chk("reset in_ready", bus.in_ready, 4'b1111);
        chk("reset busy", bus.busy, 0);
        chk_en = 1'b1;
        mon_en = 1'b1;

        // Single beat on port 0.
        push_beat(0, 96'hA5);
        step();
        step();
        #1 chk("single slot0", bus.mux_in[DW-1:0], 96'hA5);
        step();
        #1 chk("single sel", bus.mux_sel, 0);
        chk("single valid", bus.mux_in_valid, 4'b0001);
        step();
        #1 chk("single busy", bus.busy, 0);
        drain();

        // All four ports streaming.
        for (int i = 0; i < NP; i++) rate[i] = 100;
        repeat (40) step();
        drain();

        // Back-pressure on port 2 while stalled.
        stall_v = 1'b1;
        push_beat(2, 96'hD0);
        push_beat(2, 96'hD1);
        push_beat(2, 96'hD2);
        step();
        step();
        #1 chk("bp ready2 after 2 accepts", bus.in_ready[2], 0);
        step();
        #1 chk("bp ready2 held", bus.in_ready[2], 0);
        chk("bp busy while stalled", bus.busy, 1);
        drain();

        // Fairness between ports 1 and 3, then port 0 joins after a grant to 3.
        rate[1] = 100;
        rate[3] = 100;
        repeat (12) step();
        for (int n = 0; n < 4 && last_g != 3; n++) step();
        push_beat(0, 96'h0F0F_0F0F);
        repeat (8) step();
        drain();

        // Port 0 alone: push and pop on the same edge with one entry held.
        rate[0] = 100;
        step();
        step();
        for (int n = 0; n < 10; n++) begin
            step();
            #1 chk("pushpop ready0", bus.in_ready[0], 1);
        end
        drain();

        // Reset with every FIFO full and a grant in flight.
        stall_v = 1'b1;
        for (int i = 0; i < NP; i++) rate[i] = 100;
        repeat (3) step();
        stall_v = 1'b0;
        step();
        for (int i = 0; i < NP; i++) rate[i] = 0;
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        #1;
        chk("midreset mux_in_valid", bus.mux_in_valid, 0);
        chk("midreset mux_in", bus.mux_in, 0);
        chk("midreset in_ready", bus.in_ready, 4'b1111);
        chk("midreset busy", bus.busy, 0);
        repeat (4) step();
        drain();

        // Randomized traffic and stalls.
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0) begin
                for (int i = 0; i < NP; i++) rate[i] = $urandom_range(100);
            end
            stall_v = ($urandom_range(99) < 20);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
